// File: rtl/icache_line_fill.sv
// icache_line_fill
// Fetches one instruction-cache line after a miss. The memory burst starts at
// the critical word and wraps around the line. The critical word is forwarded
// to the core as soon as it arrives. The full line is then offered to the cache
// for writing.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   miss_*_i/o         miss request from the core (valid/ready, byte address)
//   mem_req_*_i/o      burst read request to memory (critical-word address)
//   mem_rsp_*_i/o      returned words from memory (valid/ready, data)
//   crit_valid_o/data  one-cycle pulse carrying the critical word
//   line_*_i/o         assembled line to the cache (valid/ready, addr, data)
//   busy_o             high whenever a miss is being serviced
//
// state | meaning
// IDLE  | waiting for a miss; miss_ready_o high
// REQ   | presenting the burst request to memory
// FILL  | collecting WORDS_PER_LINE words in wrap order
// WRITE | offering the assembled line to the cache
module icache_line_fill #(
    parameter int INST_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                miss_valid_i,
    output logic                                miss_ready_o,
    input  logic [ADDR_WIDTH-1:0]               miss_addr_i,
    output logic                                mem_req_valid_o,
    input  logic                                mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]               mem_req_addr_o,
    input  logic                                mem_rsp_valid_i,
    input  logic [INST_SIZE-1:0]                mem_rsp_data_i,
    output logic                                mem_rsp_ready_o,
    output logic                                crit_valid_o,
    output logic [INST_SIZE-1:0]                crit_data_o,
    output logic                                line_valid_o,
    input  logic                                line_ready_i,
    output logic [ADDR_WIDTH-1:0]               line_addr_o,
    output logic [WORDS_PER_LINE*INST_SIZE-1:0] line_data_o,
    output logic                                busy_o
);

    localparam int OFFSET    = $clog2(INST_SIZE / 8);
    localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
    localparam int LINE_BITS = WORDS_PER_LINE * INST_SIZE;

    localparam logic [WORD_BITS:0] LAST_CNT = (WORD_BITS + 1)'(WORDS_PER_LINE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [WORD_BITS-1:0]  wr_idx_q,     wr_idx_d;
    logic [WORD_BITS:0]    cnt_q,        cnt_d;
    logic [LINE_BITS-1:0]  line_q,       line_d;
    logic                  crit_valid_q, crit_valid_d;
    logic [INST_SIZE-1:0]  crit_data_q,  crit_data_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wr_idx_d     = wr_idx_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;

        case (state_q)
            S_IDLE: begin
                if (miss_valid_i) begin
                    addr_d   = miss_addr_i;
                    wr_idx_d = miss_addr_i[OFFSET +: WORD_BITS];
                    cnt_d    = '0;
                    // Start every miss from an empty line so nothing from an
                    // earlier or aborted fill can leak into the new one.
                    line_d   = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_rsp_valid_i) begin
                    line_d[int'(wr_idx_q) * INST_SIZE +: INST_SIZE] = mem_rsp_data_i;
                    wr_idx_d = wr_idx_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    // The first word of the burst is the critical word; it is
                    // forwarded only once per miss.
                    if (cnt_q == '0) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = mem_rsp_data_i;
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (line_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wr_idx_q     <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wr_idx_q     <= wr_idx_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
        end
    end

    assign miss_ready_o    = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign mem_req_valid_o = (state_q == S_REQ);
    assign mem_rsp_ready_o = (state_q == S_FILL);
    assign line_valid_o    = (state_q == S_WRITE);
    assign mem_req_addr_o  = {addr_q[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
    assign line_addr_o     = {addr_q[ADDR_WIDTH-1:OFFSET+WORD_BITS], {(OFFSET + WORD_BITS){1'b0}}};
    assign line_data_o     = line_q;
    assign crit_valid_o    = crit_valid_q;
    assign crit_data_o     = crit_data_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill
// Testbench for icache_line_fill with the default parameters (32-bit words,
// 8 words per line). It runs directed misses and randomised misses. A
// line-level reference model predicts the expected results: the critical-word
// address, the line address, the slot each returned word lands in, and the
// critical word.
module tb_icache_line_fill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_addr;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         mem_rsp_ready;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         line_valid;
    logic         line_ready;
    logic [31:0]  line_addr;
    logic [255:0] line_data;
    logic         busy;

    icache_line_fill dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_valid_i    (miss_valid),
        .miss_ready_o    (miss_ready),
        .miss_addr_i     (miss_addr),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data),
        .mem_rsp_ready_o (mem_rsp_ready),
        .crit_valid_o    (crit_valid),
        .crit_data_o     (crit_data),
        .line_valid_o    (line_valid),
        .line_ready_i    (line_ready),
        .line_addr_o     (line_addr),
        .line_data_o     (line_data),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] words [8];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miss_ready"},    256'(miss_ready),    256'(1));
        chk({tag, "_mem_req_valid"}, 256'(mem_req_valid), 256'(0));
        chk({tag, "_mem_rsp_ready"}, 256'(mem_rsp_ready), 256'(0));
        chk({tag, "_crit_valid"},    256'(crit_valid),    256'(0));
        chk({tag, "_line_valid"},    256'(line_valid),    256'(0));
        chk({tag, "_busy"},          256'(busy),          256'(0));
        chk({tag, "_crit_data"},     256'(crit_data),     256'(0));
        chk({tag, "_line_addr"},     256'(line_addr),     256'(0));
        chk({tag, "_line_data"},     line_data,           256'(0));
        chk({tag, "_mem_req_addr"},  256'(mem_req_addr),  256'(0));
    endtask

    // One complete miss. The memory returns words[0..7] in burst order.
    // abort_after > 0 asserts reset once that many words have been accepted.
    task automatic run_miss(input logic [31:0] addr, input int req_wait, input bit gap,
                            input int line_stall, input bit hold_miss, input bit stray,
                            input int abort_after, input bit chk_lat);
        int start;
        int k;
        int cyc;
        int lat;
        int crit_cnt;
        int seen;
        bit offer;
        logic [255:0] exp_line;
        logic [31:0]  exp_req;
        logic [31:0]  exp_la;

        start    = int'(addr[4:2]);
        exp_req  = addr & 32'hFFFF_FFFC;
        exp_la   = addr & 32'hFFFF_FFE0;
        exp_line = '0;
        for (int j = 0; j < 8; j++) exp_line[((start + j) % 8) * 32 +: 32] = words[j];

        chk("idle_miss_ready", 256'(miss_ready), 256'(1));
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        lat = 1;
        if (!hold_miss) begin
            miss_valid = 1'b0;
            miss_addr  = $urandom;
        end
        chk("req_busy", 256'(busy), 256'(1));
        chk("req_miss_ready", 256'(miss_ready), 256'(0));

        for (int i = 0; i < req_wait; i++) begin
            chk("req_valid_wait", 256'(mem_req_valid), 256'(1));
            chk("req_addr_wait", 256'(mem_req_addr), 256'(exp_req));
            if (stray) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = $urandom;
                chk("req_rsp_ready", 256'(mem_rsp_ready), 256'(0));
            end
            tick();
            lat++;
        end
        mem_rsp_valid = 1'b0;
        chk("req_valid", 256'(mem_req_valid), 256'(1));
        chk("req_addr", 256'(mem_req_addr), 256'(exp_req));
        mem_req_ready = 1'b1;
        tick();
        lat++;
        mem_req_ready = 1'b0;

        k = 0;
        cyc = 0;
        crit_cnt = 0;
        while (k < 8 && cyc < 64) begin
            if (abort_after != 0 && k == abort_after) begin
                mem_rsp_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("abort");
                tick();
                tick();
                rst_n = 1'b1;
                seen = 0;
                for (int i = 0; i < 12; i++) begin
                    tick();
                    if (crit_valid || line_valid || busy) seen++;
                end
                chk("abort_quiet", 256'(seen), 256'(0));
                return;
            end
            offer = !(gap && cyc[0]);
            mem_rsp_valid = offer;
            mem_rsp_data  = offer ? words[k] : $urandom;
            if (offer) chk("fill_rsp_ready", 256'(mem_rsp_ready), 256'(1));
            tick();
            lat++;
            cyc++;
            if (offer) k++;
            if (crit_valid) begin
                crit_cnt++;
                chk("crit_data", 256'(crit_data), 256'(words[0]));
            end
        end
        mem_rsp_valid = 1'b0;
        if (k < 8) chk("fill_timeout", 256'(k), 256'(8));

        chk("write_line_valid", 256'(line_valid), 256'(1));
        if (chk_lat) chk("latency", 256'(lat), 256'(10));
        chk("write_line_addr", 256'(line_addr), 256'(exp_la));
        chk("write_line_data", line_data, exp_line);
        chk("write_miss_ready", 256'(miss_ready), 256'(0));
        for (int i = 0; i < line_stall; i++) begin
            tick();
            if (crit_valid) crit_cnt++;
            chk("stall_line_valid", 256'(line_valid), 256'(1));
            chk("stall_line_data", line_data, exp_line);
            chk("stall_miss_ready", 256'(miss_ready), 256'(0));
        end
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        miss_valid = 1'b0;
        if (crit_valid) crit_cnt++;
        chk("crit_pulses", 256'(crit_cnt), 256'(1));
        chk("done_busy", 256'(busy), 256'(0));
        chk("done_line_valid", 256'(line_valid), 256'(0));
        chk("done_miss_ready", 256'(miss_ready), 256'(1));
    endtask

    initial begin
        rst_n         = 1'b0;
        miss_valid    = 1'b0;
        miss_addr     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        line_ready    = 1'b0;
        #1;
        chk_reset_outputs("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post_rst");

        // Stray responses while idle must be ignored.
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = $urandom;
            chk("stray_rsp_ready", 256'(mem_rsp_ready), 256'(0));
            tick();
            chk("stray_busy", 256'(busy), 256'(0));
        end
        mem_rsp_valid = 1'b0;

        // Critical word in slot 4, back-to-back memory, zero-wait latency.
        for (int j = 0; j < 8; j++) words[j] = 32'hA0 + 32'(j);
        run_miss(32'h0000_1010, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("slot4", 256'(line_data[4*32 +: 32]), 256'(32'hA0));

        // Start index 7: wrap immediately after the first word.
        for (int j = 0; j < 8; j++) words[j] = $urandom;
        run_miss(32'h0000_201C, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);

        // Slow request accept, gapped responses, stray responses in REQ.
        for (int j = 0; j < 8; j++) words[j] = $urandom;
        run_miss(32'h0000_4A28, 5, 1'b1, 0, 1'b0, 1'b1, 0, 1'b0);

        // Consumer stalls with a new miss held pending throughout.
        for (int j = 0; j < 8; j++) words[j] = $urandom;
        run_miss(32'h0000_5064, 0, 1'b0, 4, 1'b1, 1'b0, 0, 1'b0);

        // Reset after three words, then a clean fill.
        for (int j = 0; j < 8; j++) words[j] = $urandom;
        run_miss(32'h0000_6008, 0, 1'b0, 0, 1'b0, 1'b0, 3, 1'b0);
        for (int j = 0; j < 8; j++) words[j] = $urandom;
        run_miss(32'h0000_3000, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);

        // Randomised misses.
        for (int n = 0; n < 24; n++) begin
            for (int j = 0; j < 8; j++) words[j] = $urandom;
            run_miss($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 0, 1'b0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

Interface
REQ-001 Parameter INST_SIZE, default 32, width of one word in bits.
REQ-002 Parameter WORDS_PER_LINE, default 8, words per cache line; power of two, >=2.
REQ-003 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 Derived constants: OFFSET = log2(INST_SIZE/8) = 2; WORD_BITS = log2(WORDS_PER_LINE) = 3; LINE_BITS = WORDS_PER_LINE*INST_SIZE = 256.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 miss_valid  in  1  cache miss request present.
REQ-008 miss_ready  out  1  block can accept a miss.
REQ-009 miss_addr  in  ADDR_WIDTH  byte address of the missed instruction.
REQ-010 mem_req_valid  out  1  burst read request to memory.
REQ-011 mem_req_ready  in  1  memory accepts request.
REQ-012 mem_req_addr  out  ADDR_WIDTH  word-aligned address of critical word (low OFFSET bits zero).
REQ-013 mem_rsp_valid  in  1  one returned word valid.
REQ-014 mem_rsp_data  in  INST_SIZE  returned word.
REQ-015 mem_rsp_ready  out  1  block accepts returned word.
REQ-016 crit_valid  out  1  one-cycle pulse: critical word forwarded to core.
REQ-017 crit_data  out  INST_SIZE  critical word.
REQ-018 line_valid  out  1  assembled line ready for cache write.
REQ-019 line_ready  in  1  cache accepts line.
REQ-020 line_addr  out  ADDR_WIDTH  line-aligned address (low OFFSET+WORD_BITS bits zero).
REQ-021 line_data  out  LINE_BITS  word i at bits [i*INST_SIZE +: INST_SIZE].
REQ-022 busy  out  1  high in any state other than IDLE.

Function
REQ-023 FSM states SHALL be IDLE, REQ, FILL, WRITE.
REQ-024 IDLE: miss_ready=1; on miss_valid, latch miss_addr, set start index = miss_addr[OFFSET +: WORD_BITS], go REQ.
REQ-025 REQ: mem_req_valid=1, mem_req_addr = latched address with low OFFSET bits cleared, held stable until mem_req_ready; on mem_req_valid&&mem_req_ready go FILL.
REQ-026 Memory returns WORDS_PER_LINE words in wrap order: start, start+1, ..., modulo WORDS_PER_LINE.
REQ-027 FILL: mem_rsp_ready=1; each accepted word written to line slot given by a WORD_BITS-bit write index that starts at start index and increments with natural wrap (7 -> 0).
REQ-028 A separate count (WORD_BITS+1 bits) SHALL track words received; go WRITE in the cycle after the WORDS_PER_LINE-th word is accepted.
REQ-029 First accepted word SHALL produce crit_valid=1 for exactly one cycle in the following cycle with crit_data = that word; never again for the same miss.
REQ-030 mem_rsp_valid outside FILL SHALL be ignored (mem_rsp_ready=0, no state change).
REQ-031 WRITE: line_valid=1, line_data and line_addr held stable until line_ready; on line_valid&&line_ready go IDLE.
REQ-032 miss_ready=0 in REQ, FILL, WRITE; miss_valid there is ignored and not queued.
REQ-033 Handshake on line and miss in the same cycle not possible (different states); a new miss accepted earliest one cycle after line handshake.
REQ-034 Miss-to-line latency with zero-wait memory and ready consumer: 1 (REQ) + 8 (FILL) + 1 (WRITE) cycles after miss accept.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, count=0, and outputs: miss_ready=1 (after release, IDLE), mem_req_valid=0, mem_rsp_ready=0, crit_valid=0, line_valid=0, busy=0, crit_data=0, line_addr=0, line_data=0, mem_req_addr=0.
REQ-036 Reset asserted mid-fill SHALL discard the partial line; no line_valid or crit_valid after release until a new miss completes.

Verification
REQ-037 Miss 0x0000_1010, mem returns 0xA0..0xA7 back-to-back -> mem_req_addr=0x1010, crit_data=0xA0, line_addr=0x1000, line_data slot4=0xA0, slot7=0xA3, slot0=0xA4, slot3=0xA7.
REQ-038 Miss 0x0000_201C (start index 7) -> words land in slots 7,0,1..6; wrap verified; crit_data = first word.
REQ-039 mem_req_ready low 5 cycles, mem_rsp_valid gapped every other cycle -> mem_req_addr stable, line correct, crit_valid exactly one pulse.
REQ-040 line_ready low 4 cycles in WRITE, miss_valid high throughout -> line_data stable, miss_ready=0, new miss accepted only after line handshake.
REQ-041 rst_n low after 3 words -> all outputs at reset values; next miss 0x3000 fills clean line with no stale slots.
REQ-042 Stray mem_rsp_valid in IDLE -> ignored, busy stays 0.
